// File: rtl/ase_sim_local_mem_pkg.sv
// rtl/ase_sim_local_mem_pkg.sv - shared types and helpers for the local memory write path
package ase_sim_local_mem_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } t_wr_rsp_state;

    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/ase_sim_wr_rsp_fifo.sv
// rtl/ase_sim_wr_rsp_fifo.sv - write response FIFO with registered valid/data outputs
module ase_sim_wr_rsp_fifo
    import ase_sim_local_mem_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop_ready,
    output logic                     rd_valid,
    output logic [WIDTH-1:0]         rd_data,
    output logic [$clog2(DEPTH):0]   used
);
    localparam int PW = ptr_width(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    used_q, used_d;
    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             do_push, do_pop;

    always_comb begin
        do_pop   = valid_q && pop_ready;
        do_push  = push && ((used_q != CW'(DEPTH)) || do_pop);
        wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = do_pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        used_d   = used_q + CW'(do_push) - CW'(do_pop);
        valid_d  = (used_d != '0);
        // Head slot is being written this cycle only when the FIFO drains to that slot
        data_d   = (do_push && (wr_ptr_q == rd_ptr_d)) ? push_data : mem_q[rd_ptr_d];
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            used_q   <= '0;
            valid_q  <= 1'b0;
            data_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            used_q   <= used_d;
            valid_q  <= valid_d;
            data_q   <= data_d;
        end
    end

    assign rd_valid = valid_q;
    assign rd_data  = data_q;
    assign used     = used_q;

endmodule

// File: rtl/ase_sim_avmm_local_wr_rsp.sv
// rtl/ase_sim_avmm_local_wr_rsp.sv - write pass-through generating one local response per burst
module ase_sim_avmm_local_wr_rsp
    import ase_sim_local_mem_pkg::*;
#(
    parameter int ADDR_WIDTH      = 27,
    parameter int DATA_WIDTH      = 512,
    parameter int BURST_CNT_WIDTH = 8,
    parameter int USER_WIDTH      = 16,
    parameter int RSP_FIFO_DEPTH  = 16
) (
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic                              src_write,
    input  logic [ADDR_WIDTH-1:0]             src_address,
    input  logic [DATA_WIDTH-1:0]             src_writedata,
    input  logic [DATA_WIDTH/8-1:0]           src_byteenable,
    input  logic [BURST_CNT_WIDTH-1:0]        src_burstcount,
    input  logic [USER_WIDTH-1:0]             src_user,
    output logic                              src_waitrequest,
    output logic                              sink_write,
    output logic [ADDR_WIDTH-1:0]             sink_address,
    output logic [DATA_WIDTH-1:0]             sink_writedata,
    output logic [DATA_WIDTH/8-1:0]           sink_byteenable,
    output logic [BURST_CNT_WIDTH-1:0]        sink_burstcount,
    input  logic                              sink_waitrequest,
    output logic                              rsp_valid,
    output logic [USER_WIDTH-1:0]             rsp_user,
    input  logic                              rsp_ready,
    output logic [$clog2(RSP_FIFO_DEPTH):0]   rsp_outstanding,
    output logic                              err_zero_burst
);
    localparam int CW = $clog2(RSP_FIFO_DEPTH) + 1;

    t_wr_rsp_state              state_q, state_d;
    logic [BURST_CNT_WIDTH-1:0] beats_left_q, beats_left_d, burst_len;
    logic [USER_WIDTH-1:0]      user_q, user_d, push_user;
    logic [CW-1:0]              reserved_q, reserved_d, used, occupancy;
    logic                       err_q, err_d;
    logic                       block, accept, first_beat, last_beat;

    assign sink_address    = src_address;
    assign sink_writedata  = src_writedata;
    assign sink_byteenable = src_byteenable;
    assign sink_burstcount = src_burstcount;

    always_comb begin
        // Used plus reserved never exceeds the depth, so it fits the count width
        occupancy       = used + reserved_q;
        block           = (state_q == IDLE) && (occupancy == CW'(RSP_FIFO_DEPTH));
        sink_write      = src_write && !block;
        src_waitrequest = block || sink_waitrequest;
        accept          = sink_write && !sink_waitrequest;
        burst_len       = (src_burstcount == '0) ? BURST_CNT_WIDTH'(1) : src_burstcount;
        first_beat      = accept && (state_q == IDLE);
        last_beat       = accept && ((state_q == IDLE) ? (burst_len == BURST_CNT_WIDTH'(1))
                                                       : (beats_left_q == BURST_CNT_WIDTH'(1)));
        push_user       = (state_q == IDLE) ? src_user : user_q;

        state_d      = state_q;
        beats_left_d = beats_left_q;
        user_d       = user_q;
        reserved_d   = reserved_q;
        err_d        = err_q;
        if (first_beat) begin
            user_d       = src_user;
            beats_left_d = burst_len - 1'b1;
            err_d        = err_q || (src_burstcount == '0);
            if (!last_beat) begin
                state_d    = BURST;
                reserved_d = reserved_q + 1'b1;
            end
        end else if (accept) begin
            beats_left_d = beats_left_q - 1'b1;
            if (last_beat) begin
                state_d    = IDLE;
                reserved_d = reserved_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            beats_left_q <= '0;
            user_q       <= '0;
            reserved_q   <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            beats_left_q <= beats_left_d;
            user_q       <= user_d;
            reserved_q   <= reserved_d;
            err_q        <= err_d;
        end
    end

    ase_sim_wr_rsp_fifo #(
        .DEPTH (RSP_FIFO_DEPTH),
        .WIDTH (USER_WIDTH)
    ) u_rsp_fifo (
        .clk       (clk),
        .rst_n     (reset_n),
        .push      (last_beat),
        .push_data (push_user),
        .pop_ready (rsp_ready),
        .rd_valid  (rsp_valid),
        .rd_data   (rsp_user),
        .used      (used)
    );

    assign rsp_outstanding = occupancy;
    assign err_zero_burst  = err_q;

endmodule

// File: tb/tb_ase_sim_avmm_local_wr_rsp.sv
// tb/tb_ase_sim_avmm_local_wr_rsp.sv - scoreboard bench for the local write response block
module tb_ase_sim_avmm_local_wr_rsp;
    localparam int AW = 27;
    localparam int DW = 512;
    localparam int BW = 8;
    localparam int UW = 16;
    localparam int D  = 16;

    logic            clk = 1'b0;
    logic            reset_n = 1'b0;
    logic            src_write = 1'b0;
    logic [AW-1:0]   src_address = '0;
    logic [DW-1:0]   src_writedata = '0;
    logic [DW/8-1:0] src_byteenable = '0;
    logic [BW-1:0]   src_burstcount = '0;
    logic [UW-1:0]   src_user = '0;
    logic            src_waitrequest;
    logic            sink_write;
    logic [AW-1:0]   sink_address;
    logic [DW-1:0]   sink_writedata;
    logic [DW/8-1:0] sink_byteenable;
    logic [BW-1:0]   sink_burstcount;
    logic            sink_waitrequest;
    logic            rsp_valid;
    logic [UW-1:0]   rsp_user;
    logic            rsp_ready = 1'b1;
    logic [$clog2(D):0] rsp_outstanding;
    logic            err_zero_burst;

    logic            wait_fixed = 1'b1;
    logic            wr_toggle = 1'b0;
    logic            wr_phase = 1'b0;

    int checks = 0;
    int failures = 0;
    int rsp_seen = 0;
    int seen_mark;
    logic [UW-1:0] exp_q[$];

    always #5 clk = ~clk;

    always @(posedge clk) wr_phase <= ~wr_phase;
    assign sink_waitrequest = wr_toggle ? wr_phase : wait_fixed;

    ase_sim_avmm_local_wr_rsp #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURST_CNT_WIDTH(BW),
        .USER_WIDTH(UW), .RSP_FIFO_DEPTH(D)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .src_write(src_write), .src_address(src_address), .src_writedata(src_writedata),
        .src_byteenable(src_byteenable), .src_burstcount(src_burstcount), .src_user(src_user),
        .src_waitrequest(src_waitrequest),
        .sink_write(sink_write), .sink_address(sink_address), .sink_writedata(sink_writedata),
        .sink_byteenable(sink_byteenable), .sink_burstcount(sink_burstcount),
        .sink_waitrequest(sink_waitrequest),
        .rsp_valid(rsp_valid), .rsp_user(rsp_user), .rsp_ready(rsp_ready),
        .rsp_outstanding(rsp_outstanding), .err_zero_burst(err_zero_burst)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (reset_n && rsp_valid && rsp_ready) begin
            rsp_seen++;
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL rsp_unexpected actual=0x%0h required=none", rsp_user);
            end else begin
                chk("rsp_order", 32'(rsp_user), 32'(exp_q.pop_front()));
            end
        end
    end

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    // Presents one beat and returns just after the edge that accepted it
    task automatic beat(input logic [UW-1:0] user, input logic [BW-1:0] bc, input bit must_go);
        int n = 0;
        src_write      = 1'b1;
        src_user       = user;
        src_burstcount = bc;
        src_address    = AW'($urandom);
        src_writedata  = {16{$urandom}};
        src_byteenable = '1;
        @(negedge clk);
        if (must_go) chk("no_stall", 32'(sink_write && !sink_waitrequest), 32'h1);
        while (!(sink_write && !sink_waitrequest) && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout actual=stalled required=accepted");
        end
        chk("addr_pass", 32'(sink_address), 32'(src_address));
        chk("bc_pass", 32'(sink_burstcount), 32'(bc));
        sync();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        src_write = 1'b1;
        repeat (2) sync();
        chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("rst_outstanding", 32'(rsp_outstanding), 32'h0);
        chk("rst_err", 32'(err_zero_burst), 32'h0);
        chk("rst_wait_pass1", 32'(src_waitrequest), 32'h1);
        chk("rst_sink_write_pass", 32'(sink_write), 32'h1);
        wait_fixed = 1'b0;
        #1;
        chk("rst_wait_pass0", 32'(src_waitrequest), 32'h0);
        src_write = 1'b0;
        sync();
        reset_n = 1'b1;
        sync();

        // Single beat, immediate response
        exp_q.push_back(16'h0A5);
        beat(16'h0A5, 8'd1, 1'b0);
        src_write = 1'b0;
        @(negedge clk);
        chk("t1_valid", 32'(rsp_valid), 32'h1);
        chk("t1_user", 32'(rsp_user), 32'h0A5);
        chk("t1_outstanding", 32'(rsp_outstanding), 32'h1);
        @(negedge clk);
        chk("t1_valid_after", 32'(rsp_valid), 32'h0);
        chk("t1_outstanding_after", 32'(rsp_outstanding), 32'h0);

        // Burst of 4 then burst of 1 under toggling waitrequest
        sync();
        seen_mark = rsp_seen;
        wr_toggle = 1'b1;
        exp_q.push_back(16'h11);
        exp_q.push_back(16'h22);
        beat(16'h11, 8'd4, 1'b0);
        for (int i = 0; i < 3; i++) beat(16'h99, 8'd4, 1'b0);
        src_write = 1'b0;
        @(negedge clk);
        chk("t2_valid_a", 32'(rsp_valid), 32'h1);
        chk("t2_user_a", 32'(rsp_user), 32'h11);
        sync();
        beat(16'h22, 8'd1, 1'b0);
        src_write = 1'b0;
        @(negedge clk);
        chk("t2_valid_b", 32'(rsp_valid), 32'h1);
        chk("t2_user_b", 32'(rsp_user), 32'h22);
        wr_toggle = 1'b0;
        repeat (3) sync();
        chk("t2_rsp_count", 32'(rsp_seen - seen_mark), 32'h2);

        // Fill 16 with no pops, 17th first beat blocked, one pop releases it
        rsp_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            exp_q.push_back(16'h100 + 16'(i));
            beat(16'h100 + 16'(i), 8'd1, 1'b1);
        end
        src_write = 1'b0;
        @(negedge clk);
        chk("t3_full_outstanding", 32'(rsp_outstanding), 32'd16);
        sync();
        exp_q.push_back(16'h1FF);
        src_write = 1'b1;
        src_user = 16'h1FF;
        src_burstcount = 8'd1;
        repeat (2) begin
            @(negedge clk);
            chk("t3_blk_wait", 32'(src_waitrequest), 32'h1);
            chk("t3_blk_sink_write", 32'(sink_write), 32'h0);
        end
        sync();
        rsp_ready = 1'b1;
        sync();
        rsp_ready = 1'b0;
        @(negedge clk);
        chk("t3_release_sink_write", 32'(sink_write), 32'h1);
        chk("t3_release_wait", 32'(src_waitrequest), 32'h0);
        sync();
        src_write = 1'b0;
        @(negedge clk);
        chk("t3_refill_outstanding", 32'(rsp_outstanding), 32'd16);
        sync();
        rsp_ready = 1'b1;
        repeat (20) sync();
        chk("t3_drained", 32'(rsp_outstanding), 32'h0);

        // 15 used plus an in-flight 8-beat burst
        rsp_ready = 1'b0;
        for (int i = 0; i < 15; i++) begin
            exp_q.push_back(16'h200 + 16'(i));
            beat(16'h200 + 16'(i), 8'd1, 1'b1);
        end
        exp_q.push_back(16'h2AA);
        beat(16'h2AA, 8'd8, 1'b1);
        chk("t4_reserved_outstanding", 32'(rsp_outstanding), 32'd16);
        for (int j = 2; j <= 7; j++) beat(16'h0, 8'd8, 1'b1);
        rsp_ready = 1'b1;
        beat(16'h0, 8'd8, 1'b1);
        rsp_ready = 1'b0;
        chk("t4_push_pop_outstanding", 32'(rsp_outstanding), 32'd15);
        exp_q.push_back(16'h2BB);
        beat(16'h2BB, 8'd1, 1'b1);
        src_user = 16'h2CC;
        @(negedge clk);
        chk("t4_blk_wait", 32'(src_waitrequest), 32'h1);
        chk("t4_blk_sink_write", 32'(sink_write), 32'h0);
        chk("t4_full_outstanding", 32'(rsp_outstanding), 32'd16);
        sync();
        src_write = 1'b0;
        rsp_ready = 1'b1;
        repeat (20) sync();
        chk("t4_drained", 32'(rsp_outstanding), 32'h0);

        // Zero burstcount treated as one, sticky error
        chk("t5_err_before", 32'(err_zero_burst), 32'h0);
        exp_q.push_back(16'h3);
        beat(16'h3, 8'd0, 1'b1);
        src_write = 1'b0;
        @(negedge clk);
        chk("t5_valid", 32'(rsp_valid), 32'h1);
        chk("t5_user", 32'(rsp_user), 32'h3);
        chk("t5_err", 32'(err_zero_burst), 32'h1);
        repeat (3) sync();
        chk("t5_err_sticky", 32'(err_zero_burst), 32'h1);
        chk("t5_outstanding", 32'(rsp_outstanding), 32'h0);

        // Reset mid-burst discards the partial burst
        beat(16'h55, 8'd4, 1'b1);
        beat(16'h0, 8'd4, 1'b1);
        src_write = 1'b0;
        chk("t6_mid_outstanding", 32'(rsp_outstanding), 32'h1);
        reset_n = 1'b0;
        #1;
        chk("t6_rst_outstanding", 32'(rsp_outstanding), 32'h0);
        chk("t6_rst_err", 32'(err_zero_burst), 32'h0);
        chk("t6_rst_valid", 32'(rsp_valid), 32'h0);
        repeat (2) sync();
        reset_n = 1'b1;
        sync();
        exp_q.push_back(16'h7);
        beat(16'h7, 8'd1, 1'b1);
        src_write = 1'b0;
        @(negedge clk);
        chk("t6_valid", 32'(rsp_valid), 32'h1);
        chk("t6_user", 32'(rsp_user), 32'h7);
        repeat (2) sync();
        chk("t6_outstanding", 32'(rsp_outstanding), 32'h0);

        repeat (5) sync();
        chk("end_queue_empty", 32'(exp_q.size()), 32'h0);
        chk("end_rsp_count", 32'(rsp_seen), 32'd39);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
